// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared definitions for the bus_fifo_port register window:
//                register offsets, STATUS/CTRL bit positions, bus word type.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  localparam int BUS_W = 16;
  typedef logic [BUS_W-1:0] word_t;

  // Register offsets from BASE
  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_CLEAR  = 2'd3;

  // STATUS bit positions (CLEAR uses the same positions for the sticky flags)
  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_TX_FULL     = 1;
  localparam int ST_RX_OVERRUN  = 2;
  localparam int ST_TX_OVERFLOW = 3;

  // CTRL bit positions
  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_LOOPBACK = 1;

endpackage
`default_nettype wire

// File: rtl/port_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : port_fifo
//  Description : Synchronous FIFO with extra-MSB pointers. Pushes into a full
//                FIFO and pops from an empty FIFO are ignored; the full/empty
//                state before the edge decides, so a pop never makes room for
//                a same-edge push.
//  Revision    : 1.0 - initial release
// ============================================================================
module port_fifo #(
  parameter int N     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [N-1:0] wdata,
  output logic [N-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [N-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer advance; reset empties the FIFO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/bus_fifo_port.sv
`default_nettype none
// ============================================================================
//  Module      : bus_fifo_port
//  Description : Memory-mapped CPU bus responder bridging stores into a TX
//                FIFO and an external RX stream into an RX FIFO. Register
//                window BASE..BASE+3: DATA, STATUS, CTRL, CLEAR.
//                Optional macro LOOPBACK_EN adds CTRL.loopback (TX -> RX).
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_fifo_port
  import bus_pkg::*;
#(
  parameter int          N     = 16,
  parameter logic [15:0] BASE  = 16'hFF00,
  parameter int          DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  Address,
  input  logic         RW,
  input  logic [N-1:0] Din,
  output logic [N-1:0] Dout,
  output logic         Sel,
  output logic [N-1:0] tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  input  logic [N-1:0] rx_data,
  input  logic         rx_valid,
  output logic         rx_ready
);

  // ---------------- address decode and access-start detection -------------
  logic [15:0] offset;
  logic [1:0]  reg_sel;
  logic [16:0] key;
  logic [16:0] prev_key;
  logic        prev_sel;
  logic        prev_valid;
  logic        start;
  logic        wr_start;
  logic        rd_start;

  assign offset  = Address - BASE;
  assign Sel     = (offset < 16'd4);
  assign reg_sel = offset[1:0];
  assign key     = {Address, RW};

  // prev_sel resets high and prev_valid low, so an access still held when
  // reset releases is not treated as new; only a change or a deselect re-arms.
  assign start    = Sel && (!prev_sel || (prev_valid && (key != prev_key)));
  assign wr_start = start && !RW;
  assign rd_start = start && RW;

  // Track previous bus cycle for start detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_key   <= '0;
      prev_sel   <= 1'b1;
      prev_valid <= 1'b0;
    end else begin
      prev_key   <= key;
      prev_sel   <= Sel;
      prev_valid <= 1'b1;
    end
  end

  // ---------------- control and sticky flags ------------------------------
  logic enable;
  logic rx_overrun;
  logic tx_overflow;
  logic lb_on;

`ifdef LOOPBACK_EN
  logic loopback;
  assign lb_on = loopback;
`else
  assign lb_on = 1'b0;
`endif

  // ---------------- FIFOs -------------------------------------------------
  logic [N-1:0] tx_head;
  logic [N-1:0] rx_head;
  logic [N-1:0] rx_wdata;
  logic         tx_full, tx_empty, rx_full, rx_empty;
  logic         tx_push, tx_pop, rx_push, rx_pop;
  logic         store_data;
  logic         lb_move;
  logic         tx_ovf_set, rx_ovr_set;
  logic         clr_ovr, clr_ovf;

  assign store_data = wr_start && (reg_sel == OFF_DATA) && enable;
  assign tx_push    = store_data && !tx_full;
  assign tx_ovf_set = store_data && tx_full;

  assign lb_move  = lb_on && !tx_empty && !rx_full;
  assign tx_valid = !tx_empty && !lb_on;
  assign tx_data  = tx_head;
  assign tx_pop   = (tx_valid && tx_ready) || lb_move;

  assign rx_ready   = !rx_full && enable && !lb_on;
  assign rx_push    = (rx_valid && rx_ready) || lb_move;
  assign rx_wdata   = lb_move ? tx_head : rx_data;
  assign rx_ovr_set = rx_valid && rx_full && enable && !lb_on;
  assign rx_pop     = rd_start && (reg_sel == OFF_DATA) && !rx_empty;

  assign clr_ovr = wr_start && (reg_sel == OFF_CLEAR) && Din[ST_RX_OVERRUN];
  assign clr_ovf = wr_start && (reg_sel == OFF_CLEAR) && Din[ST_TX_OVERFLOW];

  port_fifo #(.N(N), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (Din),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  port_fifo #(.N(N), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rx_wdata),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // CTRL write and sticky flags; a set on the same edge as a clear wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable      <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
`ifdef LOOPBACK_EN
      loopback    <= 1'b0;
`endif
    end else begin
      if (wr_start && (reg_sel == OFF_CTRL)) begin
        enable   <= Din[CTRL_ENABLE];
`ifdef LOOPBACK_EN
        loopback <= Din[CTRL_LOOPBACK];
`endif
      end
      rx_overrun  <= rx_ovr_set || (rx_overrun && !clr_ovr);
      tx_overflow <= tx_ovf_set || (tx_overflow && !clr_ovf);
    end
  end

  // ---------------- read path ---------------------------------------------
  logic [N-1:0] rd_word;

  // Select the register image addressed by the current bus cycle
  always_comb begin
    rd_word = '0;
    case (reg_sel)
      OFF_DATA: rd_word = rx_empty ? '0 : rx_head;
      OFF_STATUS: begin
        rd_word[ST_RX_NONEMPTY] = !rx_empty;
        rd_word[ST_TX_FULL]     = tx_full;
        rd_word[ST_RX_OVERRUN]  = rx_overrun;
        rd_word[ST_TX_OVERFLOW] = tx_overflow;
      end
      OFF_CTRL: begin
        rd_word[CTRL_ENABLE] = enable;
`ifdef LOOPBACK_EN
        rd_word[CTRL_LOOPBACK] = loopback;
`endif
      end
      default: rd_word = '0;
    endcase
  end

  // Registered load data. DATA is captured only on the start edge so a held
  // load keeps showing the word it popped instead of the next head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Dout <= '0;
    end else if (Sel && RW && ((reg_sel != OFF_DATA) || start)) begin
      Dout <= rd_word;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_fifo_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_fifo_port
//  Description : Directed self-checking bench for bus_fifo_port.
//                Honours LOOPBACK_EN when the design is built with it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_fifo_port;
  import bus_pkg::*;

  localparam logic [15:0] BASE = 16'hFF00;

  logic        clk;
  logic        reset;
  logic [15:0] Address;
  logic        RW;
  word_t       Din;
  word_t       Dout;
  logic        Sel;
  word_t       tx_data;
  logic        tx_valid;
  logic        tx_ready;
  word_t       rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int total = 0;
  int bad   = 0;
  word_t rd;

  bus_fifo_port #(.N(16), .BASE(BASE), .DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .Address  (Address),
    .RW       (RW),
    .Din      (Din),
    .Dout     (Dout),
    .Sel      (Sel),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Address = 16'h0000;
    RW      = 1'b1;
    Din     = '0;
  endtask

  task automatic store(input logic [1:0] off, input word_t d);
    Address = BASE + {14'd0, off};
    RW      = 1'b0;
    Din     = d;
    cycle();
    idle();
    cycle();
  endtask

  task automatic load(input logic [1:0] off, output word_t d);
    Address = BASE + {14'd0, off};
    RW      = 1'b1;
    cycle();
    d = Dout;
    idle();
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    idle();
    cycle(); cycle();
    chk("rst_dout", Dout, 16'h0000);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_rx_ready", rx_ready, 1'b0);
    reset = 1'b1;
    cycle();

    // Decode boundaries
    Address = BASE + 16'd3; #1; chk("sel_top", Sel, 1'b1);
    Address = BASE + 16'd4; #1; chk("sel_above", Sel, 1'b0);
    Address = BASE - 16'd1; #1; chk("sel_below", Sel, 1'b0);
    idle(); cycle();

    // 1: TX path
    store(OFF_CTRL, 16'h0001);
    chk("en_rx_ready", rx_ready, 1'b1);
    store(OFF_DATA, 16'h1234);
    store(OFF_DATA, 16'hABCD);
    chk("t1_valid", tx_valid, 1'b1);
    chk("t1_head", tx_data, 16'h1234);
    tx_ready = 1'b1;
    cycle();
    chk("t1_head2", tx_data, 16'hABCD);
    chk("t1_valid2", tx_valid, 1'b1);
    cycle();
    chk("t1_drained", tx_valid, 1'b0);
    tx_ready = 1'b0;

    // 2: RX path, held load pops once
    rx_data = 16'h00F0; rx_valid = 1'b1; cycle();
    rx_data = 16'h0F0F; cycle();
    rx_valid = 1'b0;
    Address = BASE; RW = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("t2_hold_dout", Dout, 16'h00F0);
    idle(); cycle();
    load(OFF_STATUS, rd); chk("t2_status1", rd, 16'h0001);
    load(OFF_DATA, rd);   chk("t2_second", rd, 16'h0F0F);
    load(OFF_STATUS, rd); chk("t2_status0", rd, 16'h0000);
    load(OFF_DATA, rd);   chk("t2_empty_load", rd, 16'h0000);

    // 3: TX overflow and CLEAR
    for (int i = 1; i <= 9; i++) store(OFF_DATA, word_t'(i));
    load(OFF_STATUS, rd); chk("t3_status", rd, 16'h000A);
    store(OFF_CLEAR, 16'h0008);
    load(OFF_STATUS, rd); chk("t3_cleared", rd, 16'h0002);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t3_drain", tx_data, 32'(i));
      cycle();
    end
    chk("t3_empty", tx_valid, 1'b0);
    tx_ready = 1'b0;

    // 4: RX overrun, clear-vs-set priority, ordered drain
    for (int i = 0; i < 9; i++) begin
      rx_data = 16'h0100 + 16'(i); rx_valid = 1'b1;
      cycle();
    end
    chk("t4_rx_ready", rx_ready, 1'b0);
    Address = BASE + 16'd3; RW = 1'b0; Din = 16'h0004;
    cycle();
    rx_valid = 1'b0; idle(); cycle();
    load(OFF_STATUS, rd); chk("t4_set_wins", rd, 16'h0005);
    store(OFF_CLEAR, 16'h0004);
    load(OFF_STATUS, rd); chk("t4_cleared", rd, 16'h0001);
    for (int i = 0; i < 8; i++) begin
      load(OFF_DATA, rd);
      chk("t4_order", rd, 32'h0100 + 32'(i));
    end
    load(OFF_STATUS, rd); chk("t4_status0", rd, 16'h0000);

    // 5: loopback (or its absence)
    store(OFF_CTRL, 16'h0003);
`ifdef LOOPBACK_EN
    load(OFF_CTRL, rd); chk("t5_ctrl", rd, 16'h0003);
    store(OFF_DATA, 16'h5A5A);
    chk("t5_tx_valid", tx_valid, 1'b0);
    chk("t5_rx_ready", rx_ready, 1'b0);
    load(OFF_DATA, rd); chk("t5_loop", rd, 16'h5A5A);
`else
    load(OFF_CTRL, rd); chk("t5_ctrl", rd, 16'h0001);
`endif
    store(OFF_CTRL, 16'h0001);

    // 6: reset during a held DATA store
    store(OFF_DATA, 16'h0011);
    store(OFF_DATA, 16'h0022);
    rx_data = 16'h0033; rx_valid = 1'b1; cycle(); rx_valid = 1'b0;
    load(OFF_CTRL, rd); chk("t6_ctrl_pre", rd, 16'h0001);
    Address = BASE; RW = 1'b0; Din = 16'h0099;
    cycle(); cycle();
    reset = 1'b0; #2;
    chk("t6_dout", Dout, 16'h0000);
    chk("t6_tx_valid", tx_valid, 1'b0);
    chk("t6_rx_ready", rx_ready, 1'b0);
    cycle();
    reset = 1'b1;
    cycle(); cycle(); cycle();
    chk("t6_no_push", tx_valid, 1'b0);
    idle(); cycle();
    load(OFF_STATUS, rd); chk("t6_status", rd, 16'h0000);
    load(OFF_CTRL, rd);   chk("t6_ctrl", rd, 16'h0000);

    // Held CTRL write across reset must not re-fire after release
    Address = BASE + 16'd2; RW = 1'b0; Din = 16'h0001;
    cycle();
    chk("t6_en_on", rx_ready, 1'b1);
    reset = 1'b0; #2;
    chk("t6_en_rst", rx_ready, 1'b0);
    cycle();
    reset = 1'b1;
    cycle(); cycle();
    chk("t6_no_restart", rx_ready, 1'b0);
    idle(); cycle();
    store(OFF_CTRL, 16'h0001);
    chk("t6_new_start", rx_ready, 1'b1);
    store(OFF_DATA, 16'h0077);
    chk("t6_push_ok", tx_data, 16'h0077);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
